// File: rtl/dmem_responder.sv
// dmem_responder: RV32 load/store responder with programmable wait states over an owned word array.
// Optional macro DMEM_ERR_CHECK_EN enables misalignment, range and funct3 error responses.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        cap_we;
  logic [2:0]  cap_funct3;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  logic        acc_we;
  logic [2:0]  acc_f3;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        access;
  logic        legal;
  logic        sgn;
  logic        err;
  logic        commit;
  logic [1:0]  size;
  logic [1:0]  off;
  logic [AW-1:0] idx;
  logic [31:0] word;
  logic [31:0] shifted;
  logic [31:0] ld_data;
  logic [31:0] st_data;
  logic [3:0]  be;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // With zero wait states the array access lands on the accept edge, so it must see the live request.
  always_comb begin
    if (state == IDLE) begin
      acc_we    = req_we;
      acc_f3    = req_funct3;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end else begin
      acc_we    = cap_we;
      acc_f3    = cap_funct3;
      acc_addr  = cap_addr;
      acc_wdata = cap_wdata;
    end
  end

  assign access = ((state == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                  ((state == WAIT) && (cnt == '0));

  // Illegal funct3 decodes as a word access; off is the size-aligned byte offset.
  always_comb begin
    legal = acc_we ? (acc_f3 inside {3'b000, 3'b001, 3'b010})
                   : (acc_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    size  = legal ? acc_f3[1:0] : 2'd2;
    sgn   = ~acc_f3[2];
    case (size)
      2'd0:    off = acc_addr[1:0];
      2'd1:    off = {acc_addr[1], 1'b0};
      default: off = 2'b00;
    endcase
    err = 1'b0;
`ifdef DMEM_ERR_CHECK_EN
    err = !legal || (acc_addr[1:0] != off) ||
          ({2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS));
`endif
  end

`ifndef DMEM_ERR_CHECK_EN
  logic unused_hi_addr;
  assign unused_hi_addr = ^acc_addr[31:AW+2];
`endif

  assign idx     = acc_addr[AW+1:2];
  assign word    = mem[idx];
  assign shifted = word >> {off, 3'b000};

  always_comb begin
    if (acc_we || err) begin
      ld_data = '0;
    end else begin
      case (size)
        2'd0:    ld_data = {{24{sgn & shifted[7]}}, shifted[7:0]};
        2'd1:    ld_data = {{16{sgn & shifted[15]}}, shifted[15:0]};
        default: ld_data = word;
      endcase
    end
  end

  always_comb begin
    case (size)
      2'd0: begin
        st_data = {4{acc_wdata[7:0]}};
        be      = 4'b0001 << off;
      end
      2'd1: begin
        st_data = {2{acc_wdata[15:0]}};
        be      = 4'b0011 << off;
      end
      default: begin
        st_data = acc_wdata;
        be      = 4'b1111;
      end
    endcase
  end

  assign commit = access && acc_we && !err && !rst;

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int unsigned n = 0; n < 4; n++) begin
        if (be[n]) mem[idx][8*n +: 8] <= st_data[8*n +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      cap_we     <= 1'b0;
      cap_funct3 <= '0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_we     <= req_we;
            cap_funct3 <= req_funct3;
            cap_addr   <= req_addr;
            cap_wdata  <= req_wdata;
            if (WAIT_CYCLES == 0) begin
              state     <= RESP;
              rsp_rdata <= ld_data;
              rsp_err   <= err;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state     <= RESP;
            rsp_rdata <= ld_data;
            rsp_err   <= err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
